serial_adder: RTL

- Bit-serial N-bit adder built around a single `fa` full-adder instance plus a carry flip-flop.
- Processes one bit per clock, LSB first. Trades N cycles of latency for one full adder instead of an N-stage ripple chain.
- Operands are supplied by an upstream start handshake. The result is presented downstream with a one-cycle done strobe.

---
 rtl/serial_adder.sv | 107 ++++++++++
 1 files changed

// File: rtl/serial_adder.sv
// Bit-serial N-bit adder: one full adder plus a carry flop.
// Consumes one operand bit per clock, LSB first.

module fa (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic s,
   output logic cout
);

   // single-bit full adder
   assign s    = a ^ b ^ cin;
   assign cout = (a & b) | (cin & (a ^ b));

endmodule

module serial_adder #(
   parameter int N = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   input  logic         cin,
   output logic         busy,
   output logic         done,
   output logic [N-1:0] sum,
   output logic         cout
);

   localparam int CW = $clog2(N) + 1;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [1:0]    st;
   logic [N-1:0]  opa;
   logic [N-1:0]  opb;
   logic [N-1:0]  res;
   logic [N-1:0]  res_nxt;
   logic          carry;
   logic [CW-1:0] cnt;
   logic          fs;
   logic          fc;
   logic          last;

   fa u_fa (
      .a    (opa[0]),
      .b    (opb[0]),
      .cin  (carry),
      .s    (fs),
      .cout (fc)
   );

   // new sum bit enters at the top, so after N steps bit 0 is the LSB
   assign res_nxt = {fs, res[N-1:1]};
   assign last    = (cnt == CW'(N - 1));

   // control FSM and bit-serial datapath
   always_ff @(posedge clk) begin
      if (rst) begin
         st    <= S_IDLE;
         opa   <= '0;
         opb   <= '0;
         res   <= '0;
         carry <= 1'b0;
         cnt   <= '0;
         sum   <= '0;
         cout  <= 1'b0;
      end else begin
         case (st)
            S_IDLE, S_DONE: begin
               if (start) begin
                  opa   <= a;
                  opb   <= b;
                  carry <= cin;
                  cnt   <= '0;
                  st    <= S_RUN;
               end else begin
                  st    <= S_IDLE;
               end
            end
            S_RUN: begin
               opa   <= opa >> 1;
               opb   <= opb >> 1;
               res   <= res_nxt;
               carry <= fc;
               cnt   <= cnt + CW'(1);
               if (last) begin
                  sum  <= res_nxt;
                  cout <= fc;
                  st   <= S_DONE;
               end
            end
            default: st <= S_IDLE;
         endcase
      end
   end

   // status decoded straight from the registered state
   assign busy = (st == S_RUN);
   assign done = (st == S_DONE);

endmodule
